// File: rtl/tdm_demux4_if.sv
// rtl/tdm_demux4_if.sv - beat bus and lane outputs of the 4-lane TDM demultiplexer
interface tdm_demux4_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_sof;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic             frame_err;
  logic [1:0]       sel;

  modport master (
    output din, din_valid, din_sof,
    input  a, b, c, d, out_valid, frame_err, sel
  );

  modport slave (
    input  din, din_valid, din_sof,
    output a, b, c, d, out_valid, frame_err, sel
  );
endinterface

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - reassembles sof-aligned 4-beat frames into lane words a..d
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux4_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_nxt;
  logic [1:0]       sel_q, sel_nxt;
  logic [WIDTH-1:0] sh0_q, sh1_q, sh2_q;
  logic [WIDTH-1:0] sh0_nxt, sh1_nxt, sh2_nxt;
  logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic [WIDTH-1:0] a_nxt, b_nxt, c_nxt, d_nxt;
  logic             ov_q, ov_nxt;
  logic             fe_q, fe_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      ov_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      sel_q   <= sel_nxt;
      sh0_q   <= sh0_nxt;
      sh1_q   <= sh1_nxt;
      sh2_q   <= sh2_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      c_q     <= c_nxt;
      d_q     <= d_nxt;
      ov_q    <= ov_nxt;
      fe_q    <= fe_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    sel_nxt   = sel_q;
    sh0_nxt   = sh0_q;
    sh1_nxt   = sh1_q;
    sh2_nxt   = sh2_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    c_nxt     = c_q;
    d_nxt     = d_q;
    ov_nxt    = 1'b0;
    fe_nxt    = 1'b0;

    if (bus.din_valid) begin
      case (state_q)
        IDLE: begin
          // Beats without sof are discarded until the link is aligned.
          if (bus.din_sof) begin
            sh0_nxt   = bus.din;
            sel_nxt   = 2'd1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (bus.din_sof) begin
            // Early sof: drop the partial frame and restart on this beat.
            fe_nxt  = 1'b1;
            sh0_nxt = bus.din;
            sel_nxt = 2'd1;
          end else begin
            case (sel_q)
              2'd1: begin
                sh1_nxt = bus.din;
                sel_nxt = 2'd2;
              end
              2'd2: begin
                sh2_nxt = bus.din;
                sel_nxt = 2'd3;
              end
              2'd3: begin
                a_nxt     = sh0_q;
                b_nxt     = sh1_q;
                c_nxt     = sh2_q;
                d_nxt     = bus.din;
                ov_nxt    = 1'b1;
                sel_nxt   = 2'd0;
                state_nxt = IDLE;
              end
              default: begin
                sh0_nxt = bus.din;
                sel_nxt = 2'd1;
              end
            endcase
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.c         = c_q;
  assign bus.d         = d_q;
  assign bus.out_valid = ov_q;
  assign bus.frame_err = fe_q;
  assign bus.sel       = sel_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - bench for tdm_demux4 against a frame-assembly reference model
module tb_tdm_demux4;

  logic clk;
  logic rst_n;

  tdm_demux4_if #(.WIDTH(8)) bus ();

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference: beats of the frame in progress, plus the expected registered outputs.
  logic [7:0]  part[$];
  logic [31:0] exp_lanes;
  logic        exp_ov;
  logic        exp_fe;
  int          n_ov;
  int          n_fe;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    part.delete();
    exp_lanes = '0;
    exp_ov    = 1'b0;
    exp_fe    = 1'b0;
  endtask

  task automatic model_beat(input logic v, input logic sof, input logic [7:0] data);
    exp_ov = 1'b0;
    exp_fe = 1'b0;
    if (v) begin
      if (sof) begin
        exp_fe = (part.size() != 0);
        part.delete();
        part.push_back(data);
      end else if (part.size() != 0) begin
        part.push_back(data);
        if (part.size() == 4) begin
          exp_lanes = {part[0], part[1], part[2], part[3]};
          exp_ov    = 1'b1;
          part.delete();
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".lanes"}, {bus.a, bus.b, bus.c, bus.d}, exp_lanes);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_ov));
    check({tag, ".frame_err"}, 32'(bus.frame_err), 32'(exp_fe));
    check({tag, ".sel"}, 32'(bus.sel), 32'(part.size()));
    if (bus.out_valid) n_ov++;
    if (bus.frame_err) n_fe++;
  endtask

  // Present one cycle of input, let the edge sample it, then compare 1ns later.
  task automatic cycle(input string tag, input logic v, input logic sof, input logic [7:0] data);
    bus.din_valid = v;
    bus.din_sof   = sof;
    bus.din       = data;
    @(posedge clk);
    model_beat(v, sof, data);
    #1;
    check_all(tag);
  endtask

  task automatic frame(input string tag, input logic [31:0] beats, input int gap);
    logic [31:0] w;
    w = beats;
    for (int i = 0; i < 4; i++) begin
      cycle(tag, 1'b1, (i == 0), w[31-8*i -: 8]);
      for (int g = 0; g < gap; g++) cycle(tag, 1'b0, 1'b0, 8'($urandom));
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    n_ov  = 0;
    n_fe  = 0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.din_sof   = 1'b0;
    rst_n         = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Back-to-back frame
    n_ov = 0;
    frame("basic", 32'h11223344, 0);
    cycle("basic_idle", 1'b0, 1'b0, 8'h00);
    check("basic_pulses", 32'(n_ov), 32'd1);

    // Same frame with 3-cycle gaps
    n_ov = 0;
    frame("gaps", 32'h11223344, 3);
    check("gaps_pulses", 32'(n_ov), 32'd1);

    // Two frames with no gap between them
    n_ov = 0;
    n_fe = 0;
    frame("b2b1", 32'h11223344, 0);
    frame("b2b2", 32'hA1B2C3D4, 0);
    cycle("b2b_idle", 1'b0, 1'b0, 8'h00);
    check("b2b_pulses", 32'(n_ov), 32'd2);
    check("b2b_no_err", 32'(n_fe), 32'd0);
    check("b2b_lanes", {bus.a, bus.b, bus.c, bus.d}, 32'hA1B2C3D4);

    // Aborted frame followed by restart
    n_fe = 0;
    cycle("abort", 1'b1, 1'b1, 8'h01);
    cycle("abort", 1'b1, 1'b0, 8'h02);
    frame("restart", 32'h55667788, 0);
    check("abort_err_pulses", 32'(n_fe), 32'd1);
    check("abort_lanes", {bus.a, bus.b, bus.c, bus.d}, 32'h55667788);

    // Unaligned beats after reset are ignored
    rst_n = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b1;
    n_fe = 0;
    cycle("noalign", 1'b1, 1'b0, 8'h99);
    cycle("noalign", 1'b1, 1'b0, 8'h98);
    frame("aligned", 32'h10111213, 0);
    check("noalign_no_err", 32'(n_fe), 32'd0);

    // Asynchronous reset mid-frame
    cycle("midrst", 1'b1, 1'b1, 8'hE1);
    cycle("midrst", 1'b1, 1'b0, 8'hE2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_ov = 0;
    cycle("post_rst", 1'b1, 1'b0, 8'hE3);
    cycle("post_rst", 1'b1, 1'b0, 8'hE4);
    cycle("post_rst", 1'b0, 1'b0, 8'h00);
    check("post_rst_no_ov", 32'(n_ov), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic v, s;
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) < 2);
      cycle("rand", v, s, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
